// File: rtl/fir_coeff_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fir_coeff_loader_if
// Brief   : Coefficient-load handshake bundle between a configuration source
//           and fir_coeff_loader (start strobe, valid/ready word transfer).
// Revision: 1.0 - initial release
// ============================================================================
interface fir_coeff_loader_if #(
    parameter int NBT_COEFF = 8
);
    logic                 i_cfg_start;
    logic                 i_cfg_valid;
    logic [NBT_COEFF-1:0] i_cfg_data;
    logic                 o_cfg_ready;

    modport master (
        output i_cfg_start,
        output i_cfg_valid,
        output i_cfg_data,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_start,
        input  i_cfg_valid,
        input  i_cfg_data,
        output o_cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/fir_coeff_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fir_coeff_loader
// Brief   : Runtime FIR coefficient loader; streams NUM_COEFF words into a
//           shadow bank and commits them atomically on an i_enable strobe.
//           Optional macro FIR_CFG_CHECKSUM_EN adds a registered tap sum.
// Revision: 1.0 - initial release
// ============================================================================
module fir_coeff_loader #(
    parameter int NBT_COEFF = 8,
    parameter int NUM_COEFF = 17,
    parameter int NB_ADDR   = 5
) (
    input  wire                              clk,
    input  wire                              i_reset,
    fir_coeff_loader_if.slave                cfg,
    input  wire                              i_enable,
    output logic [NUM_COEFF*NBT_COEFF-1:0]   o_coeffs,
    output logic                             o_busy,
    output logic                             o_done,
`ifdef FIR_CFG_CHECKSUM_EN
    output logic signed [NBT_COEFF+NB_ADDR-1:0] o_checksum,
`endif
    output logic                             o_err
);

    localparam logic [1:0]         c_idle        = 2'd0;
    localparam logic [1:0]         c_load        = 2'd1;
    localparam logic [1:0]         c_wait_commit = 2'd2;
    localparam logic [NB_ADDR-1:0] c_last_tap    = NB_ADDR'(NUM_COEFF - 1);

    logic [1:0]         state_q, state_d;
    logic [NB_ADDR-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [NUM_COEFF-1:0][NBT_COEFF-1:0] shadow_q, shadow_d;
    logic [NUM_COEFF-1:0][NBT_COEFF-1:0] active_q, active_d;

    logic w_wr_en;
    logic w_commit;
    logic w_clr;
    logic w_cfg_ready;
    logic w_busy;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= c_idle;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = err_q;
        w_wr_en  = 1'b0;
        w_commit = 1'b0;
        w_clr    = 1'b0;
        case (state_q)
            c_idle: begin
                if (cfg.i_cfg_start) begin
                    state_d = c_load;
                    cnt_d   = '0;
                    w_clr   = 1'b1;
                end else if (cfg.i_cfg_valid) begin
                    err_d = 1'b1;
                end
            end
            c_load: begin
                // Restart wins over a word presented in the same cycle.
                if (cfg.i_cfg_start) begin
                    cnt_d = '0;
                    w_clr = 1'b1;
                    err_d = 1'b1;
                end else if (cfg.i_cfg_valid) begin
                    w_wr_en = 1'b1;
                    if (cnt_q == c_last_tap) begin
                        state_d = c_wait_commit;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + NB_ADDR'(1);
                    end
                end
            end
            c_wait_commit: begin
                // A start coinciding with the commit edge is a legal chain.
                if (i_enable) begin
                    w_commit = 1'b1;
                    done_d   = 1'b1;
                    if (cfg.i_cfg_start) begin
                        state_d = c_load;
                        cnt_d   = '0;
                        w_clr   = 1'b1;
                    end else begin
                        state_d = c_idle;
                    end
                end else if (cfg.i_cfg_start) begin
                    state_d = c_load;
                    cnt_d   = '0;
                    w_clr   = 1'b1;
                    err_d   = 1'b1;
                end else if (cfg.i_cfg_valid) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = c_idle;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------
    always_comb begin
        w_cfg_ready = 1'b0;
        w_busy      = 1'b0;
        case (state_q)
            c_load: begin
                w_cfg_ready = 1'b1;
                w_busy      = 1'b1;
            end
            c_wait_commit: begin
                w_busy = 1'b1;
            end
            default: begin
                w_cfg_ready = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow and active banks
    // ------------------------------------------------------------------
    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < NUM_COEFF; k++) begin
            if (w_wr_en && (cnt_q == NB_ADDR'(k))) begin
                shadow_d[k] = cfg.i_cfg_data;
            end
        end
    end

    always_comb begin
        active_d = active_q;
        if (w_commit) begin
            active_d = shadow_q;
        end
    end

`ifdef FIR_CFG_CHECKSUM_EN
    // Running sum is built word by word so the commit is a plain register copy.
    logic [NBT_COEFF+NB_ADDR-1:0] sum_q, sum_d;
    logic [NBT_COEFF+NB_ADDR-1:0] checksum_q, checksum_d;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            sum_q      <= '0;
            checksum_q <= '0;
        end else begin
            sum_q      <= sum_d;
            checksum_q <= checksum_d;
        end
    end

    always_comb begin
        sum_d      = sum_q;
        checksum_d = checksum_q;
        if (w_commit) begin
            checksum_d = sum_q;
        end
        if (w_clr) begin
            sum_d = '0;
        end else if (w_wr_en) begin
            sum_d = sum_q + {{NB_ADDR{cfg.i_cfg_data[NBT_COEFF-1]}}, cfg.i_cfg_data};
        end
    end

    assign o_checksum = $signed(checksum_q);
`endif

    assign cfg.o_cfg_ready = w_cfg_ready;
    assign o_busy          = w_busy;
    assign o_done          = done_q;
    assign o_err           = err_q;
    assign o_coeffs        = active_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fir_coeff_loader
// Brief   : Directed bench for fir_coeff_loader with a queue-based reference
//           model compared every cycle plus literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fir_coeff_loader;

    localparam int NBT = 8;
    localparam int NUM = 17;
    localparam int NBA = 5;
    localparam int CSW = NBT + NBA;

    logic clk      = 1'b0;
    logic i_reset  = 1'b0;
    logic i_enable = 1'b0;
    logic chk_on   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    fir_coeff_loader_if #(.NBT_COEFF(NBT)) cfg_if();

    wire [NUM*NBT-1:0] o_coeffs;
    wire               o_busy;
    wire               o_done;
    wire               o_err;
`ifdef FIR_CFG_CHECKSUM_EN
    wire signed [CSW-1:0] o_checksum;
`endif

    fir_coeff_loader #(
        .NBT_COEFF (NBT),
        .NUM_COEFF (NUM),
        .NB_ADDR   (NBA)
    ) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .cfg        (cfg_if),
        .i_enable   (i_enable),
        .o_coeffs   (o_coeffs),
        .o_busy     (o_busy),
        .o_done     (o_done),
`ifdef FIR_CFG_CHECKSUM_EN
        .o_checksum (o_checksum),
`endif
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    // Reference model: accepted words held in a queue, committed as a whole.
    logic [NBT-1:0]        m_active [NUM];
    logic [NBT-1:0]        m_shadow [$];
    bit                    m_loading, m_pending, m_done, m_err;
    logic signed [CSW-1:0] m_cks;

    always @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NUM; k++) m_active[k] = '0;
            m_shadow.delete();
            m_loading = 0;
            m_pending = 0;
            m_done    = 0;
            m_err     = 0;
            m_cks     = '0;
        end else begin
            m_done = 0;
            if (m_pending) begin
                if (i_enable) begin
                    int s;
                    s = 0;
                    for (int k = 0; k < NUM; k++) begin
                        m_active[k] = m_shadow[k];
                        s += int'($signed(m_shadow[k]));
                    end
                    m_cks     = CSW'(s);
                    m_done    = 1;
                    m_pending = 0;
                    if (cfg_if.i_cfg_start) begin
                        m_loading = 1;
                        m_shadow.delete();
                    end
                end else if (cfg_if.i_cfg_start) begin
                    m_pending = 0;
                    m_loading = 1;
                    m_shadow.delete();
                    m_err     = 1;
                end else if (cfg_if.i_cfg_valid) begin
                    m_err = 1;
                end
            end else if (m_loading) begin
                if (cfg_if.i_cfg_start) begin
                    m_shadow.delete();
                    m_err = 1;
                end else if (cfg_if.i_cfg_valid) begin
                    m_shadow.push_back(cfg_if.i_cfg_data);
                    if (m_shadow.size() == NUM) begin
                        m_loading = 0;
                        m_pending = 1;
                    end
                end
            end else begin
                if (cfg_if.i_cfg_start) begin
                    m_loading = 1;
                    m_shadow.delete();
                end else if (cfg_if.i_cfg_valid) begin
                    m_err = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            logic [NUM*NBT-1:0] flat;
            for (int k = 0; k < NUM; k++) flat[k*NBT +: NBT] = m_active[k];
            check("model_coeffs", o_coeffs, flat);
            check("model_busy", o_busy, m_loading | m_pending);
            check("model_ready", cfg_if.o_cfg_ready, m_loading);
            check("model_done", o_done, m_done);
            check("model_err", o_err, m_err);
`ifdef FIR_CFG_CHECKSUM_EN
            check("model_checksum", o_checksum, m_cks);
`endif
        end
    end

    function automatic logic [NBT-1:0] tap(input int k);
        return o_coeffs[k*NBT +: NBT];
    endfunction

    // Wait for the next falling edge, then present inputs for the next rising edge.
    task automatic step(input logic st, input logic vl, input logic [NBT-1:0] d, input logic en);
        @(negedge clk);
        cfg_if.i_cfg_start = st;
        cfg_if.i_cfg_valid = vl;
        cfg_if.i_cfg_data  = d;
        i_enable           = en;
    endtask

    initial begin
        cfg_if.i_cfg_start = 1'b0;
        cfg_if.i_cfg_valid = 1'b0;
        cfg_if.i_cfg_data  = '0;
        i_enable           = 1'b0;
        #1 i_reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_coeffs", o_coeffs, '0);
        check("reset_busy", o_busy, 1'b0);
        check("reset_ready", cfg_if.o_cfg_ready, 1'b0);
        check("reset_done", o_done, 1'b0);
        check("reset_err", o_err, 1'b0);
        i_reset = 1'b0;
        chk_on  = 1'b1;

        // Back-to-back load of 1..17 with enable held high
        step(1, 0, 8'h00, 1);
        for (int i = 1; i <= NUM; i++) step(0, 1, NBT'(i), 1);
        step(0, 0, 8'h00, 1);
        check("t1_old_coeffs", o_coeffs, '0);
        check("t1_busy_wait", o_busy, 1'b1);
        step(0, 0, 8'h00, 0);
        check("t1_tap0", tap(0), 8'h01);
        check("t1_tap16", tap(16), 8'h11);
        check("t1_done", o_done, 1'b1);
`ifdef FIR_CFG_CHECKSUM_EN
        check("t1_checksum", o_checksum, CSW'(153));
`endif
        step(0, 0, 8'h00, 0);
        check("t1_done_single", o_done, 1'b0);
        check("t1_idle", o_busy, 1'b0);

        // Commit held off by a low enable
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < NUM; i++) step(0, 1, NBT'(8'h20 + i), 0);
        repeat (10) step(0, 0, 8'h00, 0);
        check("t2_hold_tap0", tap(0), 8'h01);
        check("t2_hold_busy", o_busy, 1'b1);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        check("t2_tap0", tap(0), 8'h20);
        check("t2_tap16", tap(16), 8'h30);
        check("t2_done", o_done, 1'b1);

        // Restart after 8 words, then 0x7F/0x80 alternating
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h55, 0);
        step(1, 1, 8'h33, 0);
        for (int i = 0; i < NUM; i++) step(0, 1, (i % 2 == 0) ? 8'h7F : 8'h80, 0);
        step(0, 0, 8'h00, 0);
        check("t3_err", o_err, 1'b1);
        check("t3_unchanged", tap(0), 8'h20);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        check("t3_tap0", tap(0), 8'h7F);
        check("t3_tap1", tap(1), 8'h80);
        check("t3_tap16", tap(16), 8'h7F);

        // Asynchronous reset after 10 words, then a clean reload
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) step(0, 1, NBT'(8'h40 + i), 0);
        step(0, 0, 8'h00, 0);
        #2 i_reset = 1'b1;
        #1;
        check("rst_coeffs", o_coeffs, '0);
        check("rst_err", o_err, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_ready", cfg_if.o_cfg_ready, 1'b0);
        @(negedge clk);
        i_reset = 1'b0;
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < NUM; i++) step(0, 1, NBT'(8'hE0 + i), 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        check("t5_tap0", tap(0), 8'hE0);
        check("t5_tap16", tap(16), 8'hF0);
        check("t5_err", o_err, 1'b0);
`ifdef FIR_CFG_CHECKSUM_EN
        check("t5_checksum", o_checksum, CSW'(-408));
`endif

        // Start coincident with the commit edge
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < NUM; i++) step(0, 1, NBT'(8'h60 + i), 0);
        step(1, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        check("t6_tap0", tap(0), 8'h60);
        check("t6_done", o_done, 1'b1);
        check("t6_ready", cfg_if.o_cfg_ready, 1'b1);
        check("t6_err", o_err, 1'b0);
        for (int i = 0; i < NUM; i++) step(0, 1, NBT'(8'h0A + i), 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        check("t6_reload_tap0", tap(0), 8'h0A);

        // Stray word while idle
        check("t4_err_before", o_err, 1'b0);
        step(0, 1, 8'h99, 1);
        step(0, 0, 8'h00, 1);
        check("t4_err", o_err, 1'b1);
        check("t4_busy", o_busy, 1'b0);
        check("t4_ready", cfg_if.o_cfg_ready, 1'b0);
        check("t4_tap0", tap(0), 8'h0A);
        repeat (3) step(0, 0, 8'h00, 0);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Runtime coefficient configuration controller for the `fir` channel filter. It accepts a stream of `NUM_COEFF` signed coefficients over a valid/ready handshake into a shadow bank. It commits the whole set atomically to the active bank on a sample boundary, so the filter never runs with a mixed set. It sits between the configuration/register interface and the `fir` coefficient inputs, replacing the fixed init-file coefficients when runtime reprogramming is needed.

## Interface
- `NBT_COEFF`, default 8: coefficient word width in bits (signed, S(8,7) format).
- `NUM_COEFF`, default 17: number of filter taps.
- `NB_ADDR`, default 5: tap counter width; must satisfy 2^NB_ADDR ≥ NUM_COEFF.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_cfg_start`  in  1  single-cycle request to begin a new coefficient load.
- `i_cfg_valid`  in  1  `i_cfg_data` holds a valid coefficient.
- `i_cfg_data`  in  NBT_COEFF  signed coefficient; the first word goes to tap 0, the last to tap NUM_COEFF-1.
- `i_enable`  in  1  FIR sample strobe; a commit is allowed only in a cycle where it is high.
- `o_cfg_ready`  out  1  controller accepts a coefficient this cycle.
- `o_coeffs`  out  NUM_COEFF*NBT_COEFF  active bank, flattened; tap k at bits [k*NBT_COEFF +: NBT_COEFF].
- `o_busy`  out  1  high in LOAD and WAIT_COMMIT.
- `o_done`  out  1  one-cycle pulse after a commit.
- `o_err`  out  1  sticky protocol-error flag.

## Operation
- State machine states: IDLE, LOAD, WAIT_COMMIT.
- IDLE:
  - `o_cfg_ready`=0.
  - `i_cfg_start`=1 → LOAD, tap counter cleared to 0.
  - `i_cfg_valid`=1 without start → `o_err` set, word dropped.
- LOAD:
  - `o_cfg_ready`=1.
  - Each cycle with `i_cfg_valid`=1 writes `shadow[cnt]` and increments `cnt`.
  - Accepting the word at `cnt`=NUM_COEFF-1 → WAIT_COMMIT.
- WAIT_COMMIT:
  - `o_cfg_ready`=0.
  - The first cycle with `i_enable`=1 copies the full shadow bank into the active bank, pulses `o_done`, and returns to IDLE.
  - `i_cfg_valid` in this state → `o_err` set, word dropped.
- `i_cfg_start` during LOAD or WAIT_COMMIT (restart):
  - The pending load is aborted, `cnt`=0, state → LOAD, `o_err` set.
  - A word presented in the same cycle is discarded.
  - The active bank is not modified.
- `i_cfg_start` in the same cycle as a commit in WAIT_COMMIT: the commit completes, state → LOAD, no error.
- The shadow bank is never visible on `o_coeffs`. The active bank changes only at a commit, all taps on the same edge.
- No arithmetic is applied to the coefficients; words are stored bit-exact.
- `o_err` clears only on `i_reset`.

## Timing
- Reset values:
  - State IDLE, `cnt`=0.
  - Shadow and active banks all 0, so `o_coeffs`=0 (the filter outputs zero until the first commit).
  - `o_cfg_ready`=0, `o_busy`=0, `o_done`=0, `o_err`=0.
- `o_cfg_ready` and `o_busy` are decoded from the registered state. `o_done` and `o_err` are registered.
- Start sampled at edge N → `o_cfg_ready`=1 from cycle N+1.
- A word is accepted at an edge where `o_cfg_ready`=1 and `i_cfg_valid`=1. There is no backpressure inside LOAD: one word per cycle is sustained.
- Last word accepted at edge E → WAIT_COMMIT from cycle E+1.
- Commit at the first edge ≥ E+1 with `i_enable`=1. `o_coeffs` shows the new set from that edge, and `o_done` is high for exactly the following cycle.
- Minimum start-to-new-coeffs latency: NUM_COEFF+2 cycles.
- Reset asserted mid-load or mid-commit: immediate return to reset values, with no partial commit.

## Configuration
- `FIR_CFG_CHECKSUM_EN` defined:
  - Adds output `o_checksum` (NBT_COEFF+NB_ADDR bits, signed), the sum of all active-bank taps.
  - It is registered and updates on the same edge as `o_coeffs`.
  - Reset value 0.
  - The sum is accumulated in the shadow path during LOAD, with no combinational adder tree over the active bank.
- `FIR_CFG_CHECKSUM_EN` undefined: the port and the accumulator are absent; all other behaviour is identical.

## Test plan
- Reset, start, 17 words 0x01..0x11 back-to-back, `i_enable` held high:
  - `o_coeffs` tap0=0x01 and tap16=0x11 at cycle 19 after start.
  - `o_done` single pulse.
  - `o_checksum`=153 when the macro is defined.
- Full load with `i_enable` low for 10 cycles after the last word:
  - `o_coeffs` keeps its old value and `o_busy`=1.
  - Commit occurs on the first `i_enable`=1 edge.
- Restart after 8 words, then a full load of 0x7F/0x80 alternating:
  - `o_err`=1.
  - Active bank shows only the second set: tap0=0x7F, tap1=0x80.
- `i_cfg_valid`=1 in IDLE: `o_err`=1, `o_coeffs` unchanged, state stays IDLE.
- `i_reset` pulsed after 10 words: all outputs return to 0 asynchronously; a subsequent full load commits correctly.
- `i_cfg_start` coincident with a commit edge: new coefficients are committed, `o_done`=1, `o_cfg_ready`=1 the next cycle, `o_err`=0.
